// File: rtl/wb_pkg.sv
// Shared types for the Wishbone RMW bus master.
// Command opcodes and master FSM states.
package wb_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_RMW   = 2'b10,
        OP_RSVD  = 2'b11
    } wb_op_t;

    typedef enum logic [1:0] {
        M_IDLE = 2'b00,
        M_RD   = 2'b01,
        M_GAP  = 2'b10,
        M_WR   = 2'b11
    } wb_master_state_t;

endpackage

// File: rtl/wb_master_rmw_if.sv
// Command/response port plus Wishbone bus signals of the RMW master.
// The master modport is the master's own view; slave is the far side.
interface wb_master_rmw_if
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned GRANULE    = 8
);
    localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    wb_op_t                cmd_op_i;
    logic [ADDR_WIDTH-1:0] cmd_adr_i;
    logic [DATA_WIDTH-1:0] cmd_dat_i;
    logic [DATA_WIDTH-1:0] cmd_mask_i;
    logic [SEL_WIDTH-1:0]  cmd_sel_i;
    logic                  rsp_valid_o;
    logic [DATA_WIDTH-1:0] rsp_dat_o;
    logic                  rsp_err_o;
    logic [ADDR_WIDTH-1:0] adr_o;
    logic [DATA_WIDTH-1:0] dat_o;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [SEL_WIDTH-1:0]  sel_o;
    logic                  we_o;
    logic                  stb_o;
    logic                  cyc_o;
    logic                  ack_i;

    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_dat_i,
        input  cmd_mask_i, cmd_sel_i, dat_i, ack_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        output adr_o, dat_o, sel_o, we_o, stb_o, cyc_o
    );

    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_dat_i,
        output cmd_mask_i, cmd_sel_i, dat_i, ack_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  adr_o, dat_o, sel_o, we_o, stb_o, cyc_o
    );

endinterface

// File: rtl/wb_watchdog.sv
// Cycle counter that flags a stalled strobe; TIMEOUT_CYCLES=0 never expires.
module wb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int unsigned CW =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (enable_i)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Expiry is judged on the edge that would be the last allowed one.
    assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i &&
                       (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_master_rmw.sv
// Wishbone B4 classic single-transfer master running READ, WRITE and RMW commands.
// RMW keeps cyc_o asserted and drops stb_o for one GAP cycle between phases.
module wb_master_rmw
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned GRANULE        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input logic            clk_i,
    input logic            rst_i,
    wb_master_rmw_if.master bus
);
    localparam int unsigned SEL_WIDTH = DATA_WIDTH / GRANULE;

    wb_master_state_t      state_q, state_d;
    wb_op_t                op_q, op_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0] cdat_q, cdat_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [DATA_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  ready_q, ready_d;
    logic                  expired;
    logic                  abort;

    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (~stb_q),
        .enable_i (stb_q & ~bus.ack_i),
        .expired_o(expired)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        cdat_d      = cdat_q;
        mask_d      = mask_q;
        sel_d       = sel_q;
        rd_d        = rd_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        abort       = 1'b0;
        unique case (state_q)
            M_IDLE: begin
                if (bus.cmd_valid_i && ready_q) begin
                    op_d   = bus.cmd_op_i;
                    adr_d  = bus.cmd_adr_i;
                    cdat_d = bus.cmd_dat_i;
                    mask_d = bus.cmd_mask_i;
                    sel_d  = bus.cmd_sel_i;
                    unique case (bus.cmd_op_i)
                        OP_READ, OP_RMW: begin
                            state_d = M_RD;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            we_d    = 1'b0;
                        end
                        OP_WRITE: begin
                            state_d = M_WR;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            we_d    = 1'b1;
                            wdat_d  = bus.cmd_dat_i;
                        end
                        default: begin
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_dat_d   = '0;
                        end
                    endcase
                end
            end
            M_RD: begin
                if (bus.ack_i) begin
                    rd_d = bus.dat_i;
                    if (op_q == OP_RMW) begin
                        state_d = M_GAP;
                        stb_d   = 1'b0;
                        wdat_d  = (bus.dat_i & ~mask_q) | (cdat_q & mask_q);
                    end else begin
                        state_d     = M_IDLE;
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_dat_d   = bus.dat_i;
                    end
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            M_GAP: begin
                state_d = M_WR;
                stb_d   = 1'b1;
                we_d    = 1'b1;
            end
            M_WR: begin
                if (bus.ack_i) begin
                    state_d     = M_IDLE;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = (op_q == OP_RMW) ? rd_q : '0;
                end else if (expired) begin
                    abort = 1'b1;
                end
            end
            default: state_d = M_IDLE;
        endcase
        // A timed-out read of an RMW also skips the write phase.
        if (abort) begin
            state_d     = M_IDLE;
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            we_d        = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_dat_d   = '0;
        end
        ready_d = (state_d == M_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= M_IDLE;
            op_q        <= OP_READ;
            adr_q       <= '0;
            wdat_q      <= '0;
            cdat_q      <= '0;
            mask_q      <= '0;
            sel_q       <= '0;
            rd_q        <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            cdat_q      <= cdat_d;
            mask_q      <= mask_d;
            sel_q       <= sel_d;
            rd_q        <= rd_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.cmd_ready_o = ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_dat_o   = rsp_dat_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.adr_o       = adr_q;
    assign bus.dat_o       = wdat_q;
    assign bus.sel_o       = sel_q;
    assign bus.we_o        = we_q;
    assign bus.stb_o       = stb_q;
    assign bus.cyc_o       = cyc_q;

endmodule
